// File: rtl/mem_pkg.sv
// Shared encodings for the wait-state memory: access sizes, controller states
// and the data word width.
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: merges store data into the old word,
// extracts and extends load data, and flags misaligned/reserved accesses.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              signed_i,
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] store_word_o,
  output logic [WORD_W-1:0] load_data_o,
  output logic              misaligned_o
);

  logic [1:0]        lane_eff;
  logic [3:0]        byte_we;
  logic [7:0]        wbyte;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    lane_eff     = 2'b00;
    byte_we      = 4'b1111;
    wbyte        = 8'h00;
    store_word_o = old_word_i;
    misaligned_o = 1'b0;

    // Sub-word accesses are forced onto their natural boundary; size 11 acts as a word.
    case (size_i)
      SIZE_BYTE: begin
        lane_eff = lane_i;
        byte_we  = 4'b0001 << lane_i;
      end
      SIZE_HALF: begin
        lane_eff     = {lane_i[1], 1'b0};
        byte_we      = lane_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = lane_i[0];
      end
      SIZE_WORD: begin
        misaligned_o = (lane_i != 2'b00);
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase

    for (int b = 0; b < 4; b++) begin
      case (size_i)
        SIZE_BYTE: wbyte = wdata_i[7:0];
        SIZE_HALF: wbyte = b[0] ? wdata_i[15:8] : wdata_i[7:0];
        default:   wbyte = wdata_i[b*8 +: 8];
      endcase
      store_word_o[b*8 +: 8] = byte_we[b] ? wbyte : old_word_i[b*8 +: 8];
    end

    shifted = old_word_i >> {lane_eff, 3'b000};
    case (size_i)
      SIZE_BYTE: load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:   load_data_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/wait_state_memory.sv
// Byte-addressable memory with a configurable number of wait states and a
// one-cycle response strobe. Define MEM_MISALIGN_CHECK_EN to fault misaligned accesses.
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 8;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [IDX_W+1:0]  addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              capture;
  logic              mem_we;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] old_word;
  logic [WORD_W-1:0] store_word;
  logic [WORD_W-1:0] load_data;
  logic              misaligned;
  logic              fault;

  // Upper address bits are ignored so accesses wrap modulo DEPTH*4.
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  end

  assign word_idx = addr_q[IDX_W+1:2];
  assign old_word = mem_q[word_idx];

  mem_lane_align u_align (
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .signed_i     (signed_q),
    .old_word_i   (old_word),
    .wdata_i      (wdata_q),
    .store_word_o (store_word),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  assign fault = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign fault             = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    capture     = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        mem_we      = we_q & ~fault;
        rsp_rdata_d = (we_q | fault) ? '0 : load_data;
        rsp_err_d   = fault;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (capture) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr[IDX_W+1:0];
        wdata_q  <= req_wdata;
      end
    end
  end

  // NOTE: the array is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[word_idx] <= store_word;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory with WAIT_CYCLES=2; expectations follow
// the MEM_MISALIGN_CHECK_EN setting of the build.
module tb_wait_state_memory;
  import mem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  wait_state_memory #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = n; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // One request: drive in IDLE, scramble inputs after accept, time the response.
  task automatic do_req(input vec_t v);
    int lat;
    bit got;
    @(negedge clk);
    check({v.name, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = ~v.we;
    req_size   = ~v.size;
    req_signed = ~v.sgn;
    req_addr   = ~v.addr;
    req_wdata  = ~v.wdata;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({v.name, " responded"}, 32'(got), 32'd1);
    check({v.name, " latency"}, 32'(lat), 32'(W + 2));
    check({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
    @(negedge clk);
    check({v.name, " single strobe"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int acc_n;
    int rsp_n;
    int acc_cyc[4];
    int pulses;
    logic [31:0] word10;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    vecs.push_back(mk("st_w 10",      1'b1, SIZE_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0));
    vecs.push_back(mk("ld_w 10",      1'b0, SIZE_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("st_b 11",      1'b1, SIZE_BYTE, 1'b0, 32'h11,  32'hFFFFFF5A, 32'h0, 1'b0));
    vecs.push_back(mk("ld_bu 11",     1'b0, SIZE_BYTE, 1'b0, 32'h11,  32'h0,        32'h0000005A, 1'b0));
    vecs.push_back(mk("ld_bs 11",     1'b0, SIZE_BYTE, 1'b1, 32'h11,  32'h0,        32'h0000005A, 1'b0));
    vecs.push_back(mk("ld_w 10 b",    1'b0, SIZE_WORD, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0));
    vecs.push_back(mk("ld_bs 13",     1'b0, SIZE_BYTE, 1'b1, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0));
    vecs.push_back(mk("st_h 22",      1'b1, SIZE_HALF, 1'b1, 32'h22,  32'h12348001, 32'h0, 1'b0));
    vecs.push_back(mk("ld_hs 22",     1'b0, SIZE_HALF, 1'b1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0));
    vecs.push_back(mk("ld_hu 22",     1'b0, SIZE_HALF, 1'b0, 32'h22,  32'h0,        32'h00008001, 1'b0));
    vecs.push_back(mk("ld_w 20",      1'b0, SIZE_WORD, 1'b0, 32'h20,  32'h0,        32'h80010000, 1'b0));
    vecs.push_back(mk("ld_w 110 wrap",1'b0, SIZE_WORD, 1'b0, 32'h110, 32'h0,        32'hDEAD5AEF, 1'b0));
`ifdef MEM_MISALIGN_CHECK_EN
    vecs.push_back(mk("ld_h 13 fault",1'b0, SIZE_HALF, 1'b0, 32'h13,  32'h0,        32'h0, 1'b1));
    vecs.push_back(mk("st_h 13 fault",1'b1, SIZE_HALF, 1'b0, 32'h13,  32'h00001234, 32'h0, 1'b1));
    vecs.push_back(mk("ld_w 10 kept", 1'b0, SIZE_WORD, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0));
    vecs.push_back(mk("ld_w 12 fault",1'b0, SIZE_WORD, 1'b0, 32'h12,  32'h0,        32'h0, 1'b1));
    vecs.push_back(mk("ld_sz3 fault", 1'b0, 2'b11,     1'b0, 32'h10,  32'h0,        32'h0, 1'b1));
    word10 = 32'hDEAD5AEF;
`else
    vecs.push_back(mk("ld_h 13 align",1'b0, SIZE_HALF, 1'b0, 32'h13,  32'h0,        32'h0000DEAD, 1'b0));
    vecs.push_back(mk("st_h 13 align",1'b1, SIZE_HALF, 1'b0, 32'h13,  32'h00001234, 32'h0, 1'b0));
    vecs.push_back(mk("ld_w 10 new",  1'b0, SIZE_WORD, 1'b0, 32'h10,  32'h0,        32'h12345AEF, 1'b0));
    vecs.push_back(mk("ld_w 12 align",1'b0, SIZE_WORD, 1'b0, 32'h12,  32'h0,        32'h12345AEF, 1'b0));
    vecs.push_back(mk("ld_sz3 word",  1'b0, 2'b11,     1'b0, 32'h10,  32'h0,        32'h12345AEF, 1'b0));
    word10 = 32'h12345AEF;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", rsp_rdata, 32'h0);
    check("reset err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

    // Back-to-back: req_valid held high, accepts only in IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    acc_n = 0; rsp_n = 0;
    for (int c = 0; c < 4 * (W + 3) + W + 6; c++) begin
      if (acc_n == 4) req_valid = 1'b0;
      if (rsp_valid) begin
        rsp_n++;
        check("b2b rdata", rsp_rdata, word10);
      end
      if (req_valid && req_ready) begin
        acc_cyc[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    check("b2b accepts", 32'(acc_n), 32'd4);
    check("b2b responses", 32'(rsp_n), 32'd4);
    for (int k = 1; k < 4; k++) check("b2b spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(W + 3));

    // Reset during WAIT of a store aborts it.
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_WORD; req_addr = 32'h04; req_wdata = 32'h12345678;
    check("abort ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort in wait", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort rsp during reset", 32'(rsp_valid), 32'd0);
    pulses = 0;
    for (int c = 0; c < W + 4; c++) begin
      if (c == 0) check("ready after reset", 32'(req_ready), 32'd1);
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    check("abort no response", 32'(pulses), 32'd0);
    do_req(mk("ld_w 04 after abort", 1'b0, SIZE_WORD, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0));
    do_req(mk("ld_w 10 cleared", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
